dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter sharing the single-port data memory between the pipeline MEM
//  stage (port 0) and a secondary master such as DMA or debug (port 1). At most one
//  access is granted per cycle and driven onto the memory interface. Each granted
//  access gets exactly one registered response one cycle later. A wait counter
//  bounds how long port 1 can be starved.
// PARAMETERS
//  ADDR_WIDTH  32    byte-address width of requester ports
//  DATA_WIDTH  32    data width (equal to memory word width)
//  MAX_WAIT    8     consecutive denied cycles after which port 1 is forced to win (>=1)
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst_n      in   1             reset, synchronous, active-low
//  p0_req     in   1             port 0 access request, held until p0_gnt
//  p0_we      in   1             port 0: 1=write, 0=read
//  p0_addr    in   ADDR_WIDTH    port 0 byte address
//  p0_wdata   in   DATA_WIDTH    port 0 write data
//  p0_gnt     out  1             port 0 request accepted this cycle (combinational)
//  p0_rvalid  out  1             port 0 response valid (registered)
//  p0_rdata   out  DATA_WIDTH    port 0 read data; 0 for writes and errors
//  p0_err     out  1             port 0 misaligned-access error, qualified by p0_rvalid
//  p1_*       --   --            same set as p0_*, for port 1
//  mem_we     out  1             to memory MemWrite
//  mem_addr   out  ADDR_WIDTH    to memory word index = granted byte addr >> 2, zero-filled
//  mem_wdata  out  DATA_WIDTH    to memory write data
//  mem_rdata  in   DATA_WIDTH    from memory, combinational read data
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): p*_rvalid=0, p*_rdata=0, p*_err=0, wait_cnt=0,
//    last_gnt=1 so port 0 wins the first tie. p*_gnt and mem_we are 0 while rst_n=0.
//  - Grant (combinational, one-hot or none):
//    - only one req: that port wins
//    - both req: port 1 wins if wait_cnt==MAX_WAIT, otherwise arbitration policy
//      (see CONFIGURATION)
//    - no req: no grant, mem_we=0, mem_addr/mem_wdata=0
//  - Granted access drives mem_addr/mem_wdata. mem_we = we & aligned.
//    The write commits at the same posedge.
//  - Misaligned access (addr[1:0]!=0) is granted but mem_we=0; next cycle err=1, rdata=0.
//  - Response latency is 1: at the posedge of the grant, register
//    rvalid=1, rdata=(read & aligned)?mem_rdata:0, err=misaligned.
//    Ports without a grant get rvalid=0 and rdata/err=0.
//  - wait_cnt is saturating:
//    - +1 when p1_req && !p1_gnt
//    - cleared when p1_gnt or !p1_req
//    - never exceeds MAX_WAIT
//  - last_gnt updates to the granted port index and holds when there is no grant.
//  - Back-to-back grants to the same port are allowed every cycle (throughput 1/cycle).
//  - Read-after-write to the same address in consecutive cycles returns the new data.
//  - Requester changing addr/we/wdata while req=1 and not granted: the new values
//    are used. No internal buffering.
//  - Reset asserted mid-operation: a pending response is dropped (rvalid=0 next
//    cycle). A write granted in the reset cycle is suppressed.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined:
//    - ties resolved round-robin: the port != last_gnt wins
//    - wait counter still active, but redundant
//  DMEM_ARB_RR_EN undefined:
//    - fixed priority: port 0 wins ties unless wait_cnt==MAX_WAIT
// TESTING
//  1 Reset: hold rst_n=0 two cycles with both req=1 -> no gnt, mem_we=0, rvalid=0.
//  2 p0 write addr 0x10 data 0xDEADBEEF, next cycle p0 read 0x10 ->
//    mem_addr=4, mem_we=1 then 0; p0_rvalid=1, p0_rdata=0xDEADBEEF.
//  3 Both req continuously, macro undefined, MAX_WAIT=8 -> p0 granted 8 cycles,
//    then p1 one cycle, pattern repeats. p1 never waits more than 8 cycles.
//  4 Both req continuously, DMEM_ARB_RR_EN defined -> grants alternate p0,p1,p0,...
//    starting with p0 after reset.
//  5 p1 write addr 0x13 -> p1_gnt=1, mem_we=0, memory unchanged;
//    next cycle p1_rvalid=1, p1_err=1, p1_rdata=0.
//  6 rst_n=0 in the cycle after a p0 read grant -> p0_rvalid=0 after that edge,
//    and no response is delivered later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: MEM stage (port 0) vs DMA/debug (port 1).
// Define DMEM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0]         wait_q, wait_d;
    logic                  tie_p1;
    logic                  sel_we, sel_mis;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  p0_rvalid_q, p0_rvalid_d, p0_err_q, p0_err_d;
    logic                  p1_rvalid_q, p1_rvalid_d, p1_err_q, p1_err_d;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

`ifdef DMEM_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    // Round-robin: on a tie the port that did not win last time goes next.
    always_comb begin
        tie_p1     = (wait_q == WW'(MAX_WAIT)) || !last_gnt_q;
        last_gnt_d = last_gnt_q;
        if (p0_gnt)
            last_gnt_d = 1'b0;
        else if (p1_gnt)
            last_gnt_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_gnt_q <= 1'b1;
        else
            last_gnt_q <= last_gnt_d;
    end
`else
    always_comb begin
        tie_p1 = (wait_q == WW'(MAX_WAIT));
    end
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (rst_n) begin
            if (p0_req && p1_req) begin
                p1_gnt = tie_p1;
                p0_gnt = !tie_p1;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (p1_gnt) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end else if (p0_gnt) begin
            sel_we    = p0_we;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end
        sel_mis   = (sel_addr[1:0] != 2'b00);
        mem_we    = sel_we && !sel_mis;
        mem_addr  = sel_addr >> 2;
        mem_wdata = sel_wdata;
        // Only aligned reads return memory data; writes and errors respond with zero.
        rd_val    = (!sel_we && !sel_mis) ? mem_rdata : '0;
    end

    always_comb begin
        p0_rvalid_d = p0_gnt;
        p0_rdata_d  = p0_gnt ? rd_val : '0;
        p0_err_d    = p0_gnt && sel_mis;
        p1_rvalid_d = p1_gnt;
        p1_rdata_d  = p1_gnt ? rd_val : '0;
        p1_err_d    = p1_gnt && sel_mis;
        wait_d      = wait_q;
        if (!p1_req || p1_gnt)
            wait_d = '0;
        else if (wait_q != WW'(MAX_WAIT))
            wait_d = wait_q + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q      <= '0;
            p0_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p0_err_q    <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
            p1_err_q    <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            p0_rvalid_q <= p0_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p0_err_q    <= p0_err_d;
            p1_rvalid_q <= p1_rvalid_d;
            p1_rdata_q  <= p1_rdata_d;
            p1_err_q    <= p1_err_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p0_err    = p0_err_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p1_rdata  = p1_rdata_q;
    assign p1_err    = p1_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural model predicts grants and responses,
// a separate monitor checks each registered response as the DUT presents it.
module tb_dmem_arbiter;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memory the DUT talks to: 16 words, combinational read.
    logic [31:0] phys_mem [0:15];
    int cyc = 0;
    assign mem_rdata = phys_mem[mem_addr[3:0]];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 16; i++) phys_mem[i] <= 32'h0;
        end else if (mem_we) begin
            phys_mem[mem_addr[3:0]] <= mem_wdata;
        end
        cyc <= cyc + 1;
    end

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } resp_t;
    resp_t q0[$];
    resp_t q1[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] ref_mem [0:15];
    int  m_wait;
    int  m_last;
    bit  g0, g1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_port(input int p, input logic v, input logic [31:0] d, input logic e);
        resp_t r;
        bit    have;
        have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) r = (p == 0) ? q0[0] : q1[0];
        if (v) begin
            vectors++;
            if (!have || r.due != cyc || r.rdata !== d || r.err !== e) begin
                miscompares++;
                $display("FAIL p%0d_resp: got rdata %h err %b at cycle %0d, expected %s rdata %h err %b due %0d",
                         p, d, e, cyc, have ? "" : "(none)", have ? r.rdata : 32'h0,
                         have ? r.err : 1'b0, have ? r.due : -1);
            end
            if (have && r.due <= cyc) begin
                if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end else begin
            vectors++;
            if (have && r.due <= cyc) begin
                miscompares++;
                $display("FAIL p%0d_missing: got rvalid 0 at cycle %0d expected response rdata %h err %b",
                         p, cyc, r.rdata, r.err);
                if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end else if (d !== 32'h0 || e !== 1'b0) begin
                miscompares++;
                $display("FAIL p%0d_idle: got rdata %h err %b expected 0/0 without rvalid", p, d, e);
            end
        end
    endtask

    // Monitor: checks whatever the DUT presents after every edge.
    always @(posedge clk) begin
        #1;
        mon_port(0, p0_rvalid, p0_rdata, p0_err);
        mon_port(1, p1_rvalid, p1_rdata, p1_err);
    end

    // Drives one cycle, checks the combinational side, predicts the response.
    task automatic cycle(input bit rst, input bit r0, input bit w0, input logic [31:0] a0,
                         input logic [31:0] d0, input bit r1, input bit w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        int          win;
        bit          we, aligned;
        logic [31:0] a, d;
        resp_t       r;
        @(negedge clk);
        rst_n = !rst;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #2;
        win = -1;
        if (!rst) begin
            if (r0 && r1) begin
                if (m_wait == MAXW) win = 1;
`ifdef DMEM_ARB_RR_EN
                else win = 1 - m_last;
`else
                else win = 0;
`endif
            end else if (r0) win = 0;
            else if (r1) win = 1;
        end
        a = 32'h0; d = 32'h0; we = 1'b0;
        if (win == 0) begin a = a0; d = d0; we = w0; end
        if (win == 1) begin a = a1; d = d1; we = w1; end
        aligned = (a % 4) == 0;
        $display("cyc %0d rst %0b req %0b%0b gnt %0b%0b addr %h we %0b", cyc, rst, r0, r1,
                 p0_gnt, p1_gnt, a, we);
        chk("p0_gnt", 64'(p0_gnt), 64'(win == 0));
        chk("p1_gnt", 64'(p1_gnt), 64'(win == 1));
        chk("mem_we", 64'(mem_we), 64'(win >= 0 && we && aligned));
        chk("mem_addr", 64'(mem_addr), 64'(a / 4));
        chk("mem_wdata", 64'(mem_wdata), 64'(d));
        if (win >= 0) begin
            r.due   = cyc + 1;
            r.err   = !aligned;
            r.rdata = (!we && aligned) ? ref_mem[(a / 4) % 16] : 32'h0;
            if (win == 0) q0.push_back(r); else q1.push_back(r);
            if (we && aligned) ref_mem[(a / 4) % 16] = d;
        end
        if (rst) begin
            m_wait = 0;
            m_last = 1;
        end else begin
            if (r1 && win != 1) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
            else m_wait = 0;
            if (win >= 0) m_last = win;
        end
        g0 = (win == 0);
        g1 = (win == 1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom % 16) * 4;
        if ($urandom % 4 == 0) a = a + ($urandom % 4);
        return a;
    endfunction

    initial begin
        bit pend0, pend1, r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;
        int run1;
        rst_n = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        m_wait = 0; m_last = 1;

        // Reset held with both ports requesting
        cycle(1, 1, 1, 32'h4, 32'h1, 1, 1, 32'h8, 32'h2);
        cycle(1, 1, 1, 32'h4, 32'h1, 1, 1, 32'h8, 32'h2);
        // Write then read back the same word on consecutive cycles
        cycle(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        cycle(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        // Misaligned write from port 1 must leave memory untouched
        cycle(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h13, 32'h12345678);
        cycle(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        // Continuous contention: starvation bound / alternation
        run1 = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(0, 1, 0, 32'h10, 32'h0, 1, 0, 32'h14, 32'h0);
            if (g1) run1++;
        end
`ifndef DMEM_ARB_RR_EN
        chk("p1_wins_in_30", 64'(run1), 64'(3));
`else
        chk("p1_wins_in_30", 64'(run1), 64'(15));
`endif
        // Reset in the cycle after a read grant
        cycle(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        cycle(1, 1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0);
        cycle(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Randomized traffic, requests held until granted, payload may change while waiting
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 600; i++) begin
            r0 = pend0 || ($urandom % 3 != 0);
            r1 = pend1 || ($urandom % 2 == 0);
            w0 = $urandom % 2; w1 = $urandom % 2;
            a0 = rand_addr(); a1 = rand_addr();
            d0 = $urandom; d1 = $urandom;
            cycle(($urandom % 50) == 0, r0, w0, a0, d0, r1, w1, a1, d1);
            pend0 = r0 && !g0;
            pend1 = r1 && !g1;
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        chk("q0_drained", 64'(q0.size()), 64'(0));
        chk("q1_drained", 64'(q1.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
